// File: rtl/if_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_stage
// Brief    : Instruction fetch stage with a DEPTH-entry prefetch buffer that
//            keeps fetching ahead of decode and handles redirects/flushes.
// Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_stage #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchAddr,
    input  logic              flush,
    input  logic              freeze,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_id_valid,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [DATA_W-1:0] if_id_instruction
);

    localparam int unsigned c_IDX_W = $clog2(DEPTH);
    localparam int unsigned c_PTR_W = c_IDX_W + 1;
    localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned c_SUM_W = c_PTR_W + 1;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_SUM_W-1:0] c_DEPTH_S = c_SUM_W'(DEPTH);
    localparam logic [ADDR_W-1:0]  c_STEP    = ADDR_W'(PC_STEP);

    logic [c_PTR_W-1:0] wr_q, wr_d, fill_q, fill_d, rd_q, rd_d;
    logic [c_CNT_W-1:0] drop_q, drop_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic               run_q;

    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [DATA_W-1:0]  instr_mem [DEPTH];

    logic [c_PTR_W-1:0] w_alloc, w_filled;
    logic [c_SUM_W-1:0] w_used;
    logic [c_IDX_W-1:0] w_wr_idx, w_fill_idx, w_rd_idx;
    logic               w_redirect, w_grant, w_drop_rsp, w_fill_rsp, w_pop;

    assign w_alloc    = wr_q - rd_q;
    assign w_filled   = fill_q - rd_q;
    // Outstanding drops still hold credit: their responses have yet to arrive.
    assign w_used     = c_SUM_W'(w_alloc) + c_SUM_W'(drop_q);
    assign w_wr_idx   = wr_q[c_IDX_W-1:0];
    assign w_fill_idx = fill_q[c_IDX_W-1:0];
    assign w_rd_idx   = rd_q[c_IDX_W-1:0];

    assign w_redirect = branchTaken | flush;
    assign imem_req   = run_q & (w_used < c_DEPTH_S) & ~w_redirect;
    assign imem_addr  = fetch_pc_q;
    assign w_grant    = imem_req & imem_gnt;

    assign w_drop_rsp = imem_rvalid & (drop_q != '0);
    assign w_fill_rsp = imem_rvalid & (drop_q == '0) & ~w_redirect;

    assign if_id_valid       = (fill_q != rd_q);
    assign w_pop             = if_id_valid & ~freeze & ~w_redirect;
    assign if_id_pc          = if_id_valid ? pc_mem[w_rd_idx]    : '0;
    assign if_id_instruction = if_id_valid ? instr_mem[w_rd_idx] : '0;

    always_comb begin
        wr_d       = wr_q;
        fill_d     = fill_q;
        rd_d       = rd_q;
        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;

        if (w_grant) begin
            wr_d       = wr_q + c_PTR_ONE;
            fetch_pc_d = fetch_pc_q + c_STEP;
        end
        if (w_drop_rsp) begin
            drop_d = drop_q - c_CNT_ONE;
        end
        if (w_fill_rsp) begin
            fill_d = fill_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rd_d = rd_q + c_PTR_ONE;
        end

        // Every allocated-but-unfilled entry becomes a response to discard;
        // a response arriving this cycle is already accounted for.
        if (w_redirect) begin
            rd_d   = wr_q;
            fill_d = wr_q;
            drop_d = c_CNT_W'(c_SUM_W'(drop_q) + c_SUM_W'(w_alloc - w_filled)
                              - c_SUM_W'(imem_rvalid));
            if (branchTaken) begin
                fetch_pc_d = branchAddr;
            end else if (w_alloc != '0) begin
                fetch_pc_d = pc_mem[w_rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q       <= '0;
            fill_q     <= '0;
            rd_q       <= '0;
            drop_q     <= '0;
            fetch_pc_q <= RESET_PC;
            run_q      <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            fill_q     <= fill_d;
            rd_q       <= rd_d;
            drop_q     <= drop_d;
            fetch_pc_q <= fetch_pc_d;
            run_q      <= 1'b1;
        end
    end

    // Buffer payload needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            pc_mem[w_wr_idx] <= fetch_pc_q;
        end
        if (w_fill_rsp) begin
            instr_mem[w_fill_idx] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_prefetch_stage
// Brief    : Directed self-checking bench for if_prefetch_stage with a
//            fixed-latency in-order instruction memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_stage;

    localparam logic [31:0] c_KEY = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic        clk, rst, branchTaken, flush, freeze;
    logic        imem_req, imem_gnt, imem_rvalid, if_id_valid;
    logic [31:0] branchAddr, imem_addr, imem_rdata, if_id_pc, if_id_instruction;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 1;
    int cyc      = 0;
    mreq_t mq[$];

    if_prefetch_stage #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'h0),
        .PC_STEP  (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .branchTaken       (branchTaken),
        .branchAddr        (branchAddr),
        .flush             (flush),
        .freeze            (freeze),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_gnt          (imem_gnt),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // In-order memory: a grant in cycle t answers in cycle t+lat.
    initial begin
        mreq_t r;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mq.size() > 0 && mq[0].due == cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mq[0].addr ^ c_KEY;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
            @(negedge clk);
            #4;
            if (!rst) begin
                mq.delete();
            end else begin
                if (imem_rvalid) void'(mq.pop_front());
                if (imem_req && imem_gnt) begin
                    r.addr = imem_addr;
                    r.due  = cyc + lat;
                    mq.push_back(r);
                end
            end
        end
    end

    task automatic restart();
        @(negedge clk);
        rst = 1'b0; branchTaken = 1'b0; flush = 1'b0; freeze = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [64:0] obs;
        rst = 1'b0; branchTaken = 1'b0; flush = 1'b0; freeze = 1'b0;
        branchAddr = '0; imem_gnt = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        obs = {if_id_valid, if_id_pc, if_id_instruction};
        n_checks++;
        if (obs !== 65'd0) begin
            n_fail++;
            $display("FAIL reset_ifid: got %h expected %h", obs, 65'd0);
        end
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req: got %b expected 0", imem_req);
        end
        rst = 1'b1;
    endtask

    task automatic test_stream();
        logic [64:0] obs, exp;
        logic [31:0] epc, eaddr;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            #1;
            epc   = 32'(4 * (k - 3));
            eaddr = 32'(4 * (k - 1));
            exp   = (k >= 3) ? {1'b1, epc, epc ^ c_KEY} : 65'd0;
            obs   = {if_id_valid, if_id_pc, if_id_instruction};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL stream_ifid k=%0d: got %h expected %h", k, obs, exp);
            end
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== eaddr) begin
                n_fail++;
                $display("FAIL stream_req k=%0d: got req=%b addr=%h expected req=1 addr=%h",
                         k, imem_req, imem_addr, eaddr);
            end
        end
    endtask

    task automatic test_freeze();
        logic [64:0] obs, exp;
        logic [31:0] epc, eaddr;
        logic        ereq;
        lat = 1;
        restart();
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            freeze = (k >= 5 && k <= 14);
            #1;
            if (k <= 4)       epc = 32'(4 * (k - 3));
            else if (k <= 15) epc = 32'h8;
            else              epc = 32'(8 + 4 * (k - 15));
            exp = (k >= 3) ? {1'b1, epc, epc ^ c_KEY} : 65'd0;
            if (k <= 6)       begin ereq = 1'b1; eaddr = 32'(4 * (k - 1));   end
            else if (k <= 15) begin ereq = 1'b0; eaddr = '0;                 end
            else              begin ereq = 1'b1; eaddr = 32'(24 + 4 * (k - 16)); end
            obs = {if_id_valid, if_id_pc, if_id_instruction};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL freeze_ifid k=%0d: got %h expected %h", k, obs, exp);
            end
            n_checks++;
            if (imem_req !== ereq || (ereq && imem_addr !== eaddr)) begin
                n_fail++;
                $display("FAIL freeze_req k=%0d: got req=%b addr=%h expected req=%b addr=%h",
                         k, imem_req, imem_addr, ereq, eaddr);
            end
        end
        freeze = 1'b0;
    endtask

    task automatic test_branch();
        logic [64:0] obs, exp;
        logic [31:0] epc, eaddr;
        logic        ereq, ev;
        lat = 3;
        restart();
        branchAddr = 32'h100;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            branchTaken = (k == 3);
            #1;
            ev  = (k >= 8);
            epc = 32'h100 + 32'(4 * (k - 8));
            exp = ev ? {1'b1, epc, epc ^ c_KEY} : 65'd0;
            case (k)
                1:       begin ereq = 1'b1; eaddr = 32'h0;   end
                2:       begin ereq = 1'b1; eaddr = 32'h4;   end
                3, 8:    begin ereq = 1'b0; eaddr = 32'h0;   end
                9:       begin ereq = 1'b1; eaddr = 32'h110; end
                default: begin ereq = 1'b1; eaddr = 32'h100 + 32'(4 * (k - 4)); end
            endcase
            obs = {if_id_valid, if_id_pc, if_id_instruction};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL branch_ifid k=%0d: got %h expected %h", k, obs, exp);
            end
            n_checks++;
            if (imem_req !== ereq || (ereq && imem_addr !== eaddr)) begin
                n_fail++;
                $display("FAIL branch_req k=%0d: got req=%b addr=%h expected req=%b addr=%h",
                         k, imem_req, imem_addr, ereq, eaddr);
            end
        end
        branchTaken = 1'b0;
    endtask

    task automatic test_flush();
        logic [64:0] obs, exp;
        logic [31:0] epc, eaddr;
        logic        ereq, ev;
        lat = 1;
        restart();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            freeze = (k >= 8 && k <= 10);
            flush  = (k == 10);
            #1;
            ev = !(k <= 2 || k == 11 || k == 12);
            if (k <= 7)       epc = 32'(4 * (k - 3));
            else if (k <= 10) epc = 32'h14;
            else              epc = 32'h14 + 32'(4 * (k - 13));
            exp = ev ? {1'b1, epc, epc ^ c_KEY} : 65'd0;
            if (k <= 9)       begin ereq = 1'b1; eaddr = 32'(4 * (k - 1));         end
            else if (k == 10) begin ereq = 1'b0; eaddr = '0;                       end
            else              begin ereq = 1'b1; eaddr = 32'h14 + 32'(4 * (k - 11)); end
            obs = {if_id_valid, if_id_pc, if_id_instruction};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL flush_ifid k=%0d: got %h expected %h", k, obs, exp);
            end
            n_checks++;
            if (imem_req !== ereq || (ereq && imem_addr !== eaddr)) begin
                n_fail++;
                $display("FAIL flush_req k=%0d: got req=%b addr=%h expected req=%b addr=%h",
                         k, imem_req, imem_addr, ereq, eaddr);
            end
        end
        freeze = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic test_branch_flush_rvalid();
        logic [64:0] obs, exp;
        logic [31:0] epc, eaddr;
        logic        ereq, ev;
        lat = 1;
        restart();
        branchAddr = 32'h200;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            branchTaken = (k == 5);
            flush       = (k == 5);
            #1;
            ev = !(k <= 2 || k == 6 || k == 7);
            if (k <= 5) epc = 32'(4 * (k - 3));
            else        epc = 32'h200 + 32'(4 * (k - 8));
            exp = ev ? {1'b1, epc, epc ^ c_KEY} : 65'd0;
            if (k <= 4)      begin ereq = 1'b1; eaddr = 32'(4 * (k - 1));          end
            else if (k == 5) begin ereq = 1'b0; eaddr = '0;                        end
            else             begin ereq = 1'b1; eaddr = 32'h200 + 32'(4 * (k - 6)); end
            obs = {if_id_valid, if_id_pc, if_id_instruction};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL brflush_ifid k=%0d: got %h expected %h", k, obs, exp);
            end
            n_checks++;
            if (imem_req !== ereq || (ereq && imem_addr !== eaddr)) begin
                n_fail++;
                $display("FAIL brflush_req k=%0d: got req=%b addr=%h expected req=%b addr=%h",
                         k, imem_req, imem_addr, ereq, eaddr);
            end
        end
        branchTaken = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic test_midreset();
        logic [64:0] obs, exp;
        logic [31:0] epc, eaddr;
        lat = 1;
        restart();
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        obs = {if_id_valid, if_id_pc, if_id_instruction};
        n_checks++;
        if (obs !== 65'd0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_zero: got ifid=%h req=%b expected ifid=0 req=0", obs, imem_req);
        end
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            #1;
            epc   = 32'(4 * (k - 3));
            eaddr = 32'(4 * (k - 1));
            exp   = (k >= 3) ? {1'b1, epc, epc ^ c_KEY} : 65'd0;
            obs   = {if_id_valid, if_id_pc, if_id_instruction};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL midreset_ifid k=%0d: got %h expected %h", k, obs, exp);
            end
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== eaddr) begin
                n_fail++;
                $display("FAIL midreset_req k=%0d: got req=%b addr=%h expected req=1 addr=%h",
                         k, imem_req, imem_addr, eaddr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_freeze();
        test_branch();
        test_flush();
        test_branch_flush_rvalid();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_prefetch_stage.md
# if_prefetch_stage

Parametrised instruction-fetch stage with a DEPTH-entry prefetch buffer, sitting between the instruction memory port and the IF/ID boundary of the pipeline. It issues sequential fetches ahead of decode, tolerates variable memory latency through a request/grant/response handshake, and holds fetched instructions while decode is frozen. On a taken branch or a flush it redirects, empties the buffer and drops in-flight responses. Unlike a single IF/ID register, it keeps fetching while decode is stalled.

## Interface
- ADDR_W, 32, PC / address width
- DATA_W, 32, instruction width
- DEPTH, 4, prefetch buffer entries; power of two, >= 2
- RESET_PC, 0, fetch PC after reset
- PC_STEP, 4, PC increment per fetched instruction
- clk  in  1  clock; everything is synchronous to its rising edge
- rst  in  1  synchronous reset, active-low; sampled on the clk rising edge
- branchTaken  in  1  redirect fetch to branchAddr this cycle
- branchAddr  in  ADDR_W  branch target
- flush  in  1  discard buffered and in-flight instructions, then restart
- freeze  in  1  decode stalled; head entry is not consumed
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  fetch address (fetch_pc)
- imem_gnt  in  1  request accepted this cycle (imem_req && imem_gnt)
- imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant
- imem_rdata  in  DATA_W  response instruction
- if_id_valid  out  1  head entry holds a filled instruction
- if_id_pc  out  ADDR_W  PC of head entry; 0 when if_id_valid=0
- if_id_instruction  out  DATA_W  instruction of head entry; 0 when if_id_valid=0

## Operation
- State: fetch_pc; circular buffer of DEPTH entries {pc, instr}; pointers wr_ptr (allocate), fill_ptr (next entry to receive a response) and rd_ptr (head); drop_cnt, width clog2(DEPTH+1). Pointers carry one extra wrap bit.
- Allocated entries = wr_ptr - rd_ptr. Filled entries = fill_ptr - rd_ptr.
- Issue: imem_req = 1 when allocated + drop_cnt < DEPTH and no branchTaken/flush this cycle. On grant: entry[wr_ptr].pc <= fetch_pc, wr_ptr++, fetch_pc += PC_STEP (modulo 2^ADDR_W).
- Response: when imem_rvalid and drop_cnt > 0, the response is discarded and drop_cnt decrements. Otherwise entry[fill_ptr].instr <= imem_rdata and fill_ptr++.
- Output: if_id_valid = (fill_ptr != rd_ptr). Pop (rd_ptr++) when if_id_valid && !freeze && !flush && !branchTaken.
- branchTaken (priority over flush): fetch_pc <= branchAddr.
- flush without branchTaken: fetch_pc <= entry[rd_ptr].pc if allocated > 0, else fetch_pc (restart from the oldest discarded instruction).
- On either event: rd_ptr, fill_ptr <= wr_ptr (buffer empty); drop_cnt <= drop_cnt + (allocated - filled) - (this-cycle discarded-or-filled rvalid ? 1 : 0). Any rvalid in the same cycle is discarded and is not written.
- Reset (rst=0): fetch_pc=RESET_PC; all pointers and drop_cnt = 0; imem_req=0; if_id_valid=0; if_id_pc=0; if_id_instruction=0. Reset in the middle of an outstanding request abandons it. The memory side must also be reset in the same cycle; stale responses after reset are not tracked.

## Timing
- First imem_req=1 in the first cycle after rst is sampled high; imem_addr=RESET_PC.
- Grant in cycle t, response in cycle t+k (k>=1): if_id_valid=1 in cycle t+k+1. There is no bypass from imem_rdata to the outputs.
- With single-cycle memory and freeze=0, there is sustained throughput of 1 instruction per cycle.
- Redirect in cycle t: imem_req=0 in cycle t, if_id_valid=0 in cycle t+1, and imem_req=1 with imem_addr = the new PC in cycle t+1 (if credit is available).
- Buffer full (allocated + drop_cnt = DEPTH): imem_req=0 until a pop or a drop frees an entry. The freed credit is visible the next cycle.
- freeze held: outputs stay stable; fetching continues until the buffer is full.
- Pointer wrap: entry index = ptr[clog2(DEPTH)-1:0]; full/empty is resolved by the wrap bit.

## Test plan
- Reset, 1-cycle memory returning instr = addr ^ 32'hA5A5_0000, freeze=0 -> imem_addr 0,4,8…; if_id_pc 0,4,8… on consecutive cycles starting 2 cycles after reset release.
- freeze=1 for 10 cycles with DEPTH=4 -> if_id_pc frozen at 0x8, imem_req drops after 4 allocations, no instruction lost or duplicated after release.
- branchTaken with branchAddr=0x100 while 2 responses are in flight with 3-cycle latency -> both responses dropped (drop_cnt goes 2→0), next if_id_pc=0x100.
- flush with head pc=0x14 and 3 entries buffered -> buffer empties, refetch starts at 0x14, if_id_pc sequence 0x14,0x18,….
- branchTaken and flush asserted in the same cycle as imem_rvalid -> response not written, fetch_pc=branchAddr.
- rst=0 asserted mid-run for 1 cycle -> all outputs 0 the next cycle, refetch from RESET_PC.
